// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the debouncer family: FSM state encoding reused by
// every debouncer in the codebase.
package debounce_sync_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; output is the second
// stage, so downstream logic never sees the potentially metastable first flop.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments keep this a true two-stage shift; blocking
    // here would collapse meta and q into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_sync.sv
// Debounce-and-synchronise front end: a new level must be seen for
// STABLE_CYCLES consecutive synchronised samples before db_out follows.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_raw,
    output logic db_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s2;
    logic [CNT_W-1:0] cnt;
    db_state_t        state;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din_raw),
        .q     (s2)
    );

    // busy is registered alongside the state so it never glitches combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE_LO;
            cnt    <= '0;
            db_out <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle, so each is exactly one cycle wide.
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                IDLE_LO: begin
                    if (s2) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (!s2) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= IDLE_HI;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        db_out <= 1'b1;
                        rise   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!s2) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (s2) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= IDLE_LO;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        db_out <= 1'b0;
                        fall   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
